seq_stream_ctrl: RTL and testbench

- Sequencing controller for the serial sequence-detector datapath.
- Accepts a parallel WIDTH-bit word and clears the external detector with a one-cycle pulse.
- Streams the word MSB-first onto the detector's x input, one bit per clock, and counts detector z assertions.
- Reports a saturating match count with a done pulse. Sits between a parallel host and the detector.

---
 rtl/seq_stream_ctrl.sv | 100 ++++++++++
 tb/tb_seq_stream_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_ctrl.sv
// rtl/seq_stream_ctrl.sv - streams a parallel word MSB-first into a serial detector and counts its matches
// Optional continuous mode (detector state carried across words): define SEQ_STREAM_CONT_EN.
module seq_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             det_rst,
  output logic             x,
  input  logic             z,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0]    LAST    = BW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [BW-1:0]    bitcnt;
  logic             accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    det_rst  = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy     = 1'b1;
        det_rst  = 1'b1;
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (bitcnt == LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
`ifdef SEQ_STREAM_CONT_EN
        // Back-to-back word: skip CLEAR so the detector keeps its history.
        ready = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = S_SHIFT;
        end
`endif
      end
      default: state_nx = S_IDLE;
    endcase

    shreg_nx = shreg;
    if (accept)                shreg_nx = din;
    else if (state == S_SHIFT) shreg_nx = {shreg[WIDTH-2:0], 1'b0};
  end

  // x is registered from the next shift-register MSB so it is glitch-free and 0 outside SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      bitcnt <= '0;
      count  <= '0;
      x      <= 1'b0;
    end else begin
      shreg <= shreg_nx;
      x     <= (state_nx == S_SHIFT) ? shreg_nx[WIDTH-1] : 1'b0;
      if (accept) begin
        bitcnt <= '0;
        count  <= '0;
      end else if (state == S_SHIFT) begin
        bitcnt <= bitcnt + 1'b1;
        if (z && (count != CNT_MAX)) count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb/tb_seq_stream_ctrl.sv - scoreboard bench for seq_stream_ctrl with an 0110 overlapping detector model
module tb_seq_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;

  logic       ready, busy, det_rst, x, z, done;
  logic [3:0] count;
  logic       ready2, busy2, det_rst2, x2, z2, done2;
  logic [0:0] count2;

  logic [1:0] ds, ds2;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_push = 0;
  int n_done = 0;

  typedef struct {
    logic [7:0] word;
    int cnt;
    int cnt_sat;
    int clr_cyc;
    int done_cyc;
  } exp_t;
  exp_t sbq[$];

  seq_stream_ctrl #(.WIDTH(8), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .din(din), .ready(ready), .busy(busy),
    .det_rst(det_rst), .x(x), .z(z), .count(count), .done(done)
  );

  seq_stream_ctrl #(.WIDTH(8), .CNT_W(1)) u_sat (
    .clk(clk), .reset(reset), .start(start), .din(din), .ready(ready2), .busy(busy2),
    .det_rst(det_rst2), .x(x2), .z(z2), .count(count2), .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mealy 0110 detector with overlap; it only advances while the controller is streaming.
  function automatic logic [1:0] dnext(input logic [1:0] s, input logic xi);
    case (s)
      2'd0:    dnext = xi ? 2'd0 : 2'd1;
      2'd1:    dnext = xi ? 2'd2 : 2'd1;
      2'd2:    dnext = xi ? 2'd3 : 2'd1;
      default: dnext = xi ? 2'd0 : 2'd1;
    endcase
  endfunction

  assign z  = (ds == 2'd3) && !x;
  assign z2 = (ds2 == 2'd3) && !x2;

  always @(posedge clk or posedge reset) begin
    if (reset)        ds <= 2'd0;
    else if (det_rst) ds <= 2'd0;
    else if (busy)    ds <= dnext(ds, x);
  end

  always @(posedge clk or posedge reset) begin
    if (reset)         ds2 <= 2'd0;
    else if (det_rst2) ds2 <= 2'd0;
    else if (busy2)    ds2 <= dnext(ds2, x2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: collects the x stream and clear pulse, compares against the scoreboard at done.
  logic [7:0] xs = 8'h00;
  int nbits = 0;
  int clr_seen = -1;
  int clr_n = 0;
  exp_t e;

  always @(negedge clk) begin
    if (reset) begin
      xs = 8'h00; nbits = 0; clr_seen = -1; clr_n = 0;
    end else begin
      if (!busy || det_rst) check("x_zero_outside_shift", 32'(x), 0);
      if (det_rst) begin
        clr_seen = cyc;
        clr_n++;
      end
      if (busy && !det_rst) begin
        xs = {xs[6:0], x};
        nbits++;
      end
      if (done) begin
        n_done++;
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          e = sbq.pop_front();
          check("count", 32'(count), e.cnt);
          check("count_sat", 32'(count2), e.cnt_sat);
          check("x_stream", 32'(xs), 32'(e.word));
          check("x_bits", nbits, 8);
          check("done_cycle", cyc, e.done_cyc);
          check("clr_cycle", clr_seen, e.clr_cyc);
          check("clr_pulses", clr_n, (e.clr_cyc < 0) ? 0 : 1);
          check("sat_done_sync", 32'(done2), 1);
        end
        xs = 8'h00; nbits = 0; clr_seen = -1; clr_n = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with start dropped.
  task automatic send(input logic [7:0] w, input int c, input int cs, input bit chained,
                      input bit track);
    exp_t ne;
    bit   cont;
    int   i;
`ifdef SEQ_STREAM_CONT_EN
    cont = chained;
`else
    cont = 1'b0;
`endif
    start = 1'b1;
    din   = w;
    i = 0;
    while (!ready && i < 30) begin
      @(negedge clk);
      i++;
    end
    check("accept", 32'(ready), 1);
    if (ready && track) begin
      ne.word     = w;
      ne.cnt      = c;
      ne.cnt_sat  = cs;
      ne.clr_cyc  = cont ? -1 : cyc + 1;
      ne.done_cyc = cont ? cyc + 9 : cyc + 10;
      sbq.push_back(ne);
      n_push++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(ready && !done) && i < 40);
    check("idle_timeout", 32'(ready && !done), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_x", 32'(x), 0);
    check("rst_count", 32'(count), 0);
    check("rst_done", 32'(done), 0);
    check("rst_det_rst", 32'(det_rst), 0);
    reset = 1'b0;
    @(negedge clk);

    // Two overlapping matches; saturating 1-bit counter stops at 1.
    send(8'b0110_0110, 2, 1, 1'b0, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("count_hold", 32'(count), 2);
    check("count_sat_hold", 32'(count2), 1);

    send(8'hFF, 0, 0, 1'b0, 1'b1);
    wait_idle();

    // Abort during bit 3 (value 1): outputs clear immediately, no done afterwards.
    send(8'b0111_0000, 0, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_abort_x", 32'(x), 1);
    reset = 1'b1;
    #1;
    check("abort_x", 32'(x), 0);
    check("abort_count", 32'(count), 0);
    check("abort_ready", 32'(ready), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_count_sat", 32'(count2), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (14) @(negedge clk);

    // start pulse during SHIFT must be ignored.
    send(8'b0110_0110, 2, 1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    din   = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Word boundary: 0000_0011 then 0000_0000 requested during DONE.
    send(8'b0000_0011, 0, 0, 1'b0, 1'b1);
    begin
      int i;
      i = 0;
      while (!done && i < 20) begin
        @(negedge clk);
        i++;
      end
    end
    check("done_wait", 32'(done), 1);
`ifdef SEQ_STREAM_CONT_EN
    send(8'h00, 1, 1, 1'b1, 1'b1);
`else
    send(8'h00, 0, 0, 1'b1, 1'b1);
`endif
    wait_idle();

    repeat (5) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    check("done_total", n_done, n_push);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
